regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU pipeline and the load/memory unit.
- Each source has a one-entry holding register with a valid/ready handshake.
- A fixed-priority arbiter favours the memory source and has a starvation guard for the ALU.
- The winning entry is registered onto the register file write port (write, write_address, write_data). Writes to x0 are discarded at acceptance.

Parameters:
ADDR_WIDTH, 5, register address width (32 architectural registers)
DATA_WIDTH, 32, register data width
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending ALU entry is forced to win (legal range 1..15)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU writeback beat offered
alu_ready  output  1  ALU beat accepted at this edge when alu_valid=1
alu_address  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
mem_valid  input  1  load writeback beat offered
mem_ready  output  1  load beat accepted at this edge when mem_valid=1
mem_address  input  ADDR_WIDTH  load destination register
mem_data  input  DATA_WIDTH  load result
flush  input  1  discard speculative ALU state (branch mispredict)
write  output  1  register file write enable
write_address  output  ADDR_WIDTH  register file write address
write_data  output  DATA_WIDTH  register file write data

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While reset=0: both holds empty, starve counter=0, write=0, write_address=0, write_data=0, alu_ready=0, mem_ready=0.
  - Outputs clear immediately on assertion, without a clock edge. Any entry in flight during reset is lost.
- Handshake:
  - A beat transfers on a rising edge where valid=1 and ready=1.
  - src_ready = (hold empty OR hold granted this cycle) AND reset deasserted. alu_ready is additionally forced 0 while flush=1.
  - Ready is combinational from hold state and grant only; it never depends on the same source's valid.
- x0:
  - A beat with address 0 is accepted normally (ready obeys the rules above), but the hold is not loaded.
  - Such a beat never produces write=1.
- Arbitration (combinational, each cycle):
  - Only mem hold valid → mem granted.
  - Only alu hold valid → alu granted.
  - Both valid → mem granted, unless starve counter == STARVE_LIMIT, in which case alu is granted.
- Starve counter (4 bits):
  - Increments when the alu hold is valid, not granted and flush=0.
  - Clears to 0 when alu is granted, when the alu hold is empty, or on flush.
  - Saturates at STARVE_LIMIT.
- Output register:
  - At each rising edge, the granted hold's address/data load write_address/write_data, write is set to 1, and that hold empties (or refills if its source handshakes on the same edge).
  - With no grant: write=0 and write_address/write_data keep their previous values.
  - Latency: a beat accepted at edge k is written at the earliest during the cycle after edge k+1; write pulses exactly one cycle per entry.
- Flush:
  - Empties the alu hold at the next edge and clears the counter.
  - Does not affect the mem hold or an already-registered output (that write still completes).
  - An alu beat offered during flush is not accepted.
  - If flush coincides with an alu grant, the flush wins: no ALU write is produced.
- Ordering:
  - Entries from the same source are written in acceptance order.
  - Cross-source same-address ordering is the issue stage's responsibility. The issue stage must not have a load and an ALU op with the same destination outstanding simultaneously.
- Throughput: one write per cycle sustained; each source can stream one beat per cycle when uncontended.

Test Plan:
1. Single ALU beat x5=0xDEADBEEF, mem idle → write=1, write_address=5, write_data=0xDEADBEEF for exactly one cycle, the cycle after the edge following acceptance.
2. ALU x3=0x11 and mem x4=0x22 accepted on the same edge → mem x4=0x22 written first, ALU x3=0x11 next cycle; alu_ready=0 while the ALU entry waits.
3. Starvation with STARVE_LIMIT=4: mem streams x8..x15 every cycle, one ALU beat x2=0x5A pending → ALU loses 4 arbitrations and is written on the 5th write cycle; mem resumes afterwards and no mem beat is lost.
4. ALU beat to x0 with data 0xFFFFFFFF → alu_ready=1, write stays 0 for 10 cycles; a following ALU x1=0x1 is written normally.
5. ALU x7=0x77 held behind a mem stream, flush pulsed for one cycle → no write to x7 ever; mem writes continue uninterrupted; counter restarts from 0.
6. Reset driven low mid-stream with both holds full → write/write_address/write_data=0 and both readies=0 before the next clock edge; after reset is released, no stale write appears.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the load unit and the ALU.
// Loads win by default; a pending ALU entry is forced through after STARVE_LIMIT losses.
module regfile_write_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_address,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  flush,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data
);

    localparam logic [3:0]            LIMIT_C = 4'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] ZERO_A  = {ADDR_WIDTH{1'b0}};

    logic                  alu_hold_valid_q, alu_hold_valid_d;
    logic [ADDR_WIDTH-1:0] alu_hold_addr_q, alu_hold_addr_d;
    logic [DATA_WIDTH-1:0] alu_hold_data_q, alu_hold_data_d;
    logic                  mem_hold_valid_q, mem_hold_valid_d;
    logic [ADDR_WIDTH-1:0] mem_hold_addr_q, mem_hold_addr_d;
    logic [DATA_WIDTH-1:0] mem_hold_data_q, mem_hold_data_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    logic grant_mem_s;
    logic grant_alu_s;
    logic alu_accept_s;
    logic mem_accept_s;

    // Fixed-priority grant with starvation override, and the resulting ready signals.
    always_comb begin
        grant_mem_s = mem_hold_valid_q
                      && !(alu_hold_valid_q && (starve_cnt_q == LIMIT_C));
        grant_alu_s = alu_hold_valid_q && !grant_mem_s;
        alu_ready   = reset && !flush && (!alu_hold_valid_q || grant_alu_s);
        mem_ready   = reset && (!mem_hold_valid_q || grant_mem_s);
        alu_accept_s = alu_valid && alu_ready;
        mem_accept_s = mem_valid && mem_ready;
    end

    // Next state of both holds, the starve counter and the write port register.
    always_comb begin
        alu_hold_valid_d = alu_hold_valid_q;
        alu_hold_addr_d  = alu_hold_addr_q;
        alu_hold_data_d  = alu_hold_data_q;
        mem_hold_valid_d = mem_hold_valid_q;
        mem_hold_addr_d  = mem_hold_addr_q;
        mem_hold_data_d  = mem_hold_data_q;
        starve_cnt_d     = starve_cnt_q;
        write_d          = 1'b0;
        write_address_d  = write_address_q;
        write_data_d     = write_data_q;

        if (flush) begin
            alu_hold_valid_d = 1'b0;
        end else begin
            if (grant_alu_s) begin
                alu_hold_valid_d = 1'b0;
            end else begin
                alu_hold_valid_d = alu_hold_valid_q;
            end
            // x0 beats are handshaken but never stored.
            if (alu_accept_s && (alu_address != ZERO_A)) begin
                alu_hold_valid_d = 1'b1;
                alu_hold_addr_d  = alu_address;
                alu_hold_data_d  = alu_data;
            end else begin
                alu_hold_addr_d  = alu_hold_addr_q;
            end
        end

        if (grant_mem_s) begin
            mem_hold_valid_d = 1'b0;
        end else begin
            mem_hold_valid_d = mem_hold_valid_q;
        end
        if (mem_accept_s && (mem_address != ZERO_A)) begin
            mem_hold_valid_d = 1'b1;
            mem_hold_addr_d  = mem_address;
            mem_hold_data_d  = mem_data;
        end else begin
            mem_hold_addr_d  = mem_hold_addr_q;
        end

        if (flush || !alu_hold_valid_q || grant_alu_s) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        // A flush coinciding with an ALU grant suppresses that write.
        if (grant_mem_s) begin
            write_d         = 1'b1;
            write_address_d = mem_hold_addr_q;
            write_data_d    = mem_hold_data_q;
        end else if (grant_alu_s && !flush) begin
            write_d         = 1'b1;
            write_address_d = alu_hold_addr_q;
            write_data_d    = alu_hold_data_q;
        end else begin
            write_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_hold_valid_q <= 1'b0;
            alu_hold_addr_q  <= {ADDR_WIDTH{1'b0}};
            alu_hold_data_q  <= {DATA_WIDTH{1'b0}};
            mem_hold_valid_q <= 1'b0;
            mem_hold_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_hold_data_q  <= {DATA_WIDTH{1'b0}};
            starve_cnt_q     <= 4'd0;
            write_q          <= 1'b0;
            write_address_q  <= {ADDR_WIDTH{1'b0}};
            write_data_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            alu_hold_valid_q <= alu_hold_valid_d;
            alu_hold_addr_q  <= alu_hold_addr_d;
            alu_hold_data_q  <= alu_hold_data_d;
            mem_hold_valid_q <= mem_hold_valid_d;
            mem_hold_addr_q  <= mem_hold_addr_d;
            mem_hold_data_q  <= mem_hold_data_d;
            starve_cnt_q     <= starve_cnt_d;
            write_q          <= write_d;
            write_address_q  <= write_address_d;
            write_data_q     <= write_data_d;
        end
    end

    assign write         = write_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the write port.
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          alu_valid, alu_ready, mem_valid, mem_ready, flush;
    logic [AW-1:0] alu_address, mem_address, write_address;
    logic [DW-1:0] alu_data, mem_data, write_data;
    logic          write;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: one pending entry per source, losses counted in cycles.
    bit          ma_v, mm_v, mw;
    int          ma_a, mm_a, mw_a;
    logic [DW-1:0] ma_d, mm_d, mw_d;
    int          lost;

    regfile_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_address(alu_address), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_address(mem_address), .mem_data(mem_data),
        .flush(flush), .write(write),
        .write_address(write_address), .write_data(write_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma_v = 1'b0; mm_v = 1'b0; mw = 1'b0;
        ma_a = 0; mm_a = 0; mw_a = 0;
        ma_d = '0; mm_d = '0; mw_d = '0;
        lost = 0;
    endtask

    // One clock cycle: check readies mid-cycle, advance model, check write port after the edge.
    task automatic step(output bit a_acc, output bit m_acc);
        bit mem_wins, alu_wins, er_a, er_m;
        bit n_av, n_mv, n_w;
        int n_aa, n_ma, n_wa, n_lost;
        logic [DW-1:0] n_ad, n_md, n_wd;
        @(negedge clock);
        mem_wins = mm_v && !(ma_v && lost >= SL);
        alu_wins = ma_v && !mem_wins;
        er_a = !flush && (!ma_v || alu_wins);
        er_m = !mm_v || mem_wins;
        check("alu_ready", {63'd0, alu_ready}, {63'd0, er_a});
        check("mem_ready", {63'd0, mem_ready}, {63'd0, er_m});
        a_acc = alu_valid && er_a;
        m_acc = mem_valid && er_m;
        n_av = ma_v && !alu_wins && !flush; n_aa = ma_a; n_ad = ma_d;
        if (a_acc && alu_address != 0) begin n_av = 1'b1; n_aa = int'(alu_address); n_ad = alu_data; end
        n_mv = mm_v && !mem_wins; n_ma = mm_a; n_md = mm_d;
        if (m_acc && mem_address != 0) begin n_mv = 1'b1; n_ma = int'(mem_address); n_md = mem_data; end
        n_w = 1'b0; n_wa = mw_a; n_wd = mw_d;
        if (mem_wins) begin n_w = 1'b1; n_wa = mm_a; n_wd = mm_d; end
        else if (alu_wins && !flush) begin n_w = 1'b1; n_wa = ma_a; n_wd = ma_d; end
        n_lost = (flush || !ma_v || alu_wins) ? 0 : ((lost < SL) ? lost + 1 : lost);
        @(posedge clock);
        #1;
        ma_v = n_av; ma_a = n_aa; ma_d = n_ad;
        mm_v = n_mv; mm_a = n_ma; mm_d = n_md;
        mw = n_w; mw_a = n_wa; mw_d = n_wd; lost = n_lost;
        check("write", {63'd0, write}, {63'd0, mw});
        check("write_address", {59'd0, write_address}, 64'(mw_a));
        check("write_data", {32'd0, write_data}, {32'd0, mw_d});
    endtask

    task automatic idle();
        alu_valid = 1'b0; mem_valid = 1'b0; flush = 1'b0;
        alu_address = '0; alu_data = '0; mem_address = '0; mem_data = '0;
    endtask

    initial begin
        bit a_acc, m_acc;
        int wr_idx, alu_pos, x7_writes, mem_next;
        idle();
        reset = 1'b0;
        model_reset();
        #12;
        check("reset_write", {63'd0, write}, 64'd0);
        check("reset_addr", {59'd0, write_address}, 64'd0);
        check("reset_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("reset_mem_ready", {63'd0, mem_ready}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Single ALU beat.
        alu_valid = 1'b1; alu_address = 5'd5; alu_data = 32'hDEADBEEF;
        step(a_acc, m_acc);
        check("t1_accept", {63'd0, a_acc}, 64'd1);
        idle();
        step(a_acc, m_acc);
        check("t1_write", {63'd0, write}, 64'd1);
        check("t1_addr", {59'd0, write_address}, 64'd5);
        check("t1_data", {32'd0, write_data}, 64'hDEADBEEF);
        step(a_acc, m_acc);
        check("t1_one_pulse", {63'd0, write}, 64'd0);

        // Same-edge ALU and load: load first.
        alu_valid = 1'b1; alu_address = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_address = 5'd4; mem_data = 32'h22;
        step(a_acc, m_acc);
        idle();
        alu_valid = 1'b1; alu_address = 5'd9; alu_data = 32'h99;
        step(a_acc, m_acc);
        check("t2_first", {59'd0, write_address}, 64'd4);
        check("t2_alu_wait", {63'd0, a_acc}, 64'd0);
        idle();
        step(a_acc, m_acc);
        check("t2_second", {32'd0, write_data}, 64'h11);
        repeat (3) step(a_acc, m_acc);

        // Starvation: load stream x8..x15 against one ALU beat.
        alu_valid = 1'b1; alu_address = 5'd2; alu_data = 32'h5A;
        mem_next = 8; wr_idx = 0; alu_pos = 0;
        mem_valid = 1'b1; mem_address = 5'(mem_next); mem_data = 32'(mem_next * 16);
        for (int i = 0; i < 20; i++) begin
            step(a_acc, m_acc);
            if (a_acc) alu_valid = 1'b0;
            if (m_acc) begin
                mem_next++;
                mem_valid = (mem_next <= 15);
                mem_address = 5'(mem_next); mem_data = 32'(mem_next * 16);
            end
            if (write) begin
                wr_idx++;
                if (write_address == 5'd2) alu_pos = wr_idx;
            end
        end
        check("t3_alu_position", 64'(alu_pos), 64'd5);
        check("t3_total_writes", 64'(wr_idx), 64'd9);
        idle();

        // Write to x0 is accepted and dropped.
        alu_valid = 1'b1; alu_address = 5'd0; alu_data = 32'hFFFFFFFF;
        step(a_acc, m_acc);
        check("t4_x0_accept", {63'd0, a_acc}, 64'd1);
        idle();
        for (int i = 0; i < 10; i++) begin
            step(a_acc, m_acc);
            check("t4_no_write", {63'd0, write}, 64'd0);
        end
        alu_valid = 1'b1; alu_address = 5'd1; alu_data = 32'h1;
        step(a_acc, m_acc);
        idle();
        step(a_acc, m_acc);
        check("t4_x1_write", {59'd0, write_address}, 64'd1);

        // Flush drops a starving ALU entry.
        x7_writes = 0;
        alu_valid = 1'b1; alu_address = 5'd7; alu_data = 32'h77;
        mem_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mem_address = 5'(16 + i); mem_data = 32'(i);
            flush = (i == 2);
            step(a_acc, m_acc);
            if (a_acc) alu_valid = 1'b0;
            if (write && write_address == 5'd7) x7_writes++;
            if (i >= 1) check("t5_mem_continuous", {63'd0, write}, 64'd1);
        end
        check("t5_no_x7", 64'(x7_writes), 64'd0);
        idle();
        repeat (2) step(a_acc, m_acc);

        // Asynchronous reset with both holds full.
        alu_valid = 1'b1; alu_address = 5'd12; alu_data = 32'hAA;
        mem_valid = 1'b1; mem_address = 5'd13; mem_data = 32'hBB;
        step(a_acc, m_acc);
        step(a_acc, m_acc);
        #2;
        reset = 1'b0;
        #1;
        check("t6_write", {63'd0, write}, 64'd0);
        check("t6_addr", {59'd0, write_address}, 64'd0);
        check("t6_data", {32'd0, write_data}, 64'd0);
        check("t6_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("t6_mem_ready", {63'd0, mem_ready}, 64'd0);
        model_reset();
        idle();
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(a_acc, m_acc);
            check("t6_no_stale", {63'd0, write}, 64'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            alu_valid   = ($urandom_range(0, 1) == 1);
            alu_address = 5'($urandom_range(0, 31));
            alu_data    = $urandom;
            mem_valid   = ($urandom_range(0, 2) != 0);
            mem_address = 5'($urandom_range(0, 31));
            mem_data    = $urandom;
            flush       = ($urandom_range(0, 9) == 0);
            step(a_acc, m_acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
